// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter with a small write FIFO, frames sent back-to-back
module uart_tx_fifo #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = 1,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          din,
  input  logic                          wr,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          tx_out,
  output logic                          busy
);
  localparam int BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BAUD_CLOCKS + 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || BAUD_CLOCKS < 1) begin : g_bad_param
    $fatal(1, "uart_tx_fifo: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                r_state, w_state;
  logic [BW-1:0]         r_baud, w_baud;
  logic [3:0]            r_bit, w_bit;
  logic                  r_stop, w_stop;
  logic [DATA_BITS-1:0]  r_shift, w_shift;
  logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
  logic                  r_par, w_par;
  logic [AW-1:0]         r_wp, r_rp;
  logic [AW:0]           r_cnt;
  logic                  r_tx, r_ovf;
  logic                  w_push, w_pop, w_bit_end, w_tx;

  assign full      = r_cnt == (AW+1)'(FIFO_DEPTH);
  assign count     = r_cnt;
  assign busy      = r_state != IDLE || r_cnt != '0;
  assign tx_out    = r_tx;
  assign overflow  = r_ovf;
  assign w_push    = wr & ~full;
  assign w_bit_end = r_baud == BW'(BAUD_CLOCKS - 1);

  always_comb begin
    w_state = r_state;
    w_baud  = (r_state == IDLE || w_bit_end) ? '0 : r_baud + BW'(1);
    w_bit   = r_bit;
    w_stop  = r_stop;
    w_shift = r_shift;
    w_par   = r_par;
    w_pop   = 1'b0;
    case (r_state)
      IDLE:   w_pop = r_cnt != '0;
      START:  if (w_bit_end) begin
        w_state = DATA;
        w_bit   = '0;
      end
      DATA:   if (w_bit_end) begin
        w_shift = r_shift >> 1;
        w_bit   = r_bit + 4'd1;
        w_stop  = 1'b0;
        if (r_bit == 4'(DATA_BITS - 1)) w_state = PARITY_MODE != 0 ? PARITY : STOP;
      end
      PARITY: if (w_bit_end) begin
        w_state = STOP;
        w_stop  = 1'b0;
      end
      STOP:   if (w_bit_end) begin
        w_stop = 1'b1;
        if (r_stop == 1'(STOP_BITS - 1)) begin
          w_state = IDLE;
          w_pop   = r_cnt != '0;
        end
      end
      default: w_state = IDLE;
    endcase
    // a pop always starts a new frame on the same edge, from IDLE or the last stop bit
    if (w_pop) begin
      w_state = START;
      w_shift = r_mem[r_rp];
      w_par   = (^r_mem[r_rp]) ^ (PARITY_MODE == 1);
    end
    w_tx = w_state == START ? 1'b0 : w_state == DATA ? w_shift[0] : w_state == PARITY ? w_par : 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_tx    <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_baud  <= w_baud;
      r_bit   <= w_bit;
      r_stop  <= w_stop;
      r_shift <= w_shift;
      r_par   <= w_par;
      r_wp    <= r_wp + AW'(w_push);
      r_rp    <= r_rp + AW'(w_pop);
      r_cnt   <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_tx    <= w_tx;
      r_ovf   <= wr & full;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= din;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three parameter variants driven with directed and random writes, checked by a frame model
module tb_uart_tx_fifo;
  localparam int B = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] din = '0;
  logic [2:0] wrv = '0;
  logic [2:0] full_v, ovf_v, tx_v, busy_v;
  logic [2:0] cnt_a, cnt_b, cnt_c;
  logic [1:0] sel = '0;
  logic       last_busy;
  int         checks = 0;
  int         failures = 0;
  wire        tx_s   = tx_v[sel];
  wire        busy_s = busy_v[sel];

  uart_tx_fifo #(.CLK_FREQUENCY(800), .BAUD_RATE(100), .DATA_BITS(8), .PARITY_MODE(1),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .din(din[7:0]), .wr(wrv[0]), .full(full_v[0]), .count(cnt_a),
    .overflow(ovf_v[0]), .tx_out(tx_v[0]), .busy(busy_v[0]));
  uart_tx_fifo #(.CLK_FREQUENCY(800), .BAUD_RATE(100), .DATA_BITS(7), .PARITY_MODE(0),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .din(din[6:0]), .wr(wrv[1]), .full(full_v[1]), .count(cnt_b),
    .overflow(ovf_v[1]), .tx_out(tx_v[1]), .busy(busy_v[1]));
  uart_tx_fifo #(.CLK_FREQUENCY(800), .BAUD_RATE(100), .DATA_BITS(8), .PARITY_MODE(2),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst(rst), .din(din[7:0]), .wr(wrv[2]), .full(full_v[2]), .count(cnt_c),
    .overflow(ovf_v[2]), .tx_out(tx_v[2]), .busy(busy_v[2]));

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_one(input int s, input logic [8:0] d);
    din = d;
    wrv = 3'(1 << s);
    tick();
    wrv = '0;
  endtask

  // expected line: start 0, data LSB first, optional parity, stop ones; each level held B cycles
  task automatic rx_frame(input int db, input int pm, input int sb, input logic [8:0] d,
                          input int pre, input string tag);
    logic [15:0] bits;
    logic        obs;
    int          n, ones;
    bits = '0;
    n = 1;
    ones = 0;
    for (int j = 0; j < db; j++) begin
      bits[n] = d[j];
      ones += int'(d[j]);
      n++;
    end
    if (pm != 0) begin
      bits[n] = (pm == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
      n++;
    end
    for (int j = 0; j < sb; j++) begin
      bits[n] = 1'b1;
      n++;
    end
    for (int k = 0; k < n; k++) begin
      obs = bits[k];
      for (int c = (k == 0) ? pre : 0; c < B; c++) begin
        if (tx_s !== bits[k]) obs = tx_s;
        last_busy = busy_s;
        tick();
      end
      chk($sformatf("%s_bit%0d", tag, k), 32'(obs), 32'(bits[k]));
    end
  endtask

  task automatic pair(input int s, input int pm, input logic [8:0] d0, input logic [8:0] d1);
    sel = 2'(s);
    din = d0;
    wrv = 3'(1 << s);
    tick();
    din = d1;
    tick();
    wrv = '0;
    chk("pair_start", 32'(tx_s), 32'(0));
    rx_frame(8, pm, 1, d0, 0, "pair0");
    rx_frame(8, pm, 1, d1, 0, "pair1");
    chk("pair_idle", 32'(busy_s), 32'(0));
  endtask

  initial begin
    logic [8:0] d;
    int s, bad;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_tx", 32'(tx_v), 32'h7);
      chk("rst_busy", 32'(busy_v), 32'h0);
      chk("rst_cnt", 32'({cnt_a, cnt_b, cnt_c}), 32'h0);
      chk("rst_full", 32'(full_v | ovf_v), 32'h0);
    end
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_tx", 32'(tx_v), 32'h7);

    sel = 2'd0;
    wr_one(0, 9'hA5);
    chk("a5_pre_tx", 32'(tx_s), 32'(1));
    chk("a5_cnt", 32'(cnt_a), 32'(1));
    tick();
    chk("a5_start_lat", 32'(tx_s), 32'(0));
    rx_frame(8, 1, 1, 9'hA5, 0, "a5");
    chk("a5_busy_last", 32'(last_busy), 32'(1));
    chk("a5_busy_drop", 32'(busy_s), 32'(0));

    for (int i = 0; i < 6; i++) begin
      din = 9'(i + 1);
      wrv = 3'b001;
      tick();
      chk("burst_cnt", 32'(cnt_a), 32'(i == 0 ? 1 : i < 5 ? i : 4));
      chk("burst_full", 32'(full_v[0]), 32'(i >= 4));
      chk("burst_ovf", 32'(ovf_v[0]), 32'(i == 5));
      chk("burst_tx", 32'(tx_s), 32'(i == 0));
    end
    wrv = '0;
    tick();
    chk("burst_ovf_end", 32'(ovf_v[0]), 32'(0));
    for (int i = 0; i < 5; i++) begin
      rx_frame(8, 1, 1, 9'(i + 1), i == 0 ? 5 : 0, $sformatf("burst%0d", i + 1));
      chk("burst_cnt_after", 32'(cnt_a), 32'(i < 4 ? 3 - i : 0));
    end
    chk("burst_idle", 32'(busy_s), 32'(0));

    sel = 2'd1;
    wr_one(1, 9'h55);
    tick();
    chk("b55_start", 32'(tx_s), 32'(0));
    rx_frame(7, 0, 2, 9'h55, 0, "b55");
    chk("b55_busy_last", 32'(last_busy), 32'(1));
    chk("b55_busy_drop", 32'(busy_s), 32'(0));

    pair(2, 2, 9'h00, 9'hFF);
    pair(0, 1, 9'h00, 9'hFF);

    sel = 2'd0;
    din = 9'h00;
    wrv = 3'b001;
    tick();
    din = 9'($urandom);
    tick();
    din = 9'($urandom);
    tick();
    wrv = '0;
    chk("rst6_cnt", 32'(cnt_a), 32'(2));
    repeat (2 * B + 2) tick();
    chk("rst6_data_low", 32'(tx_s), 32'(0));
    rst = 1'b1;
    #1;
    chk("rst6_tx", 32'(tx_s), 32'(1));
    chk("rst6_cnt0", 32'(cnt_a), 32'(0));
    chk("rst6_busy", 32'(busy_s), 32'(0));
    tick();
    tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 4 * B; i++) begin
      tick();
      if (tx_s !== 1'b1 || busy_s !== 1'b0) bad++;
    end
    chk("rst6_no_resume", 32'(bad), 32'(0));
    d = 9'($urandom);
    wr_one(0, d);
    tick();
    chk("rst6_new_start", 32'(tx_s), 32'(0));
    rx_frame(8, 1, 1, d, 0, "rst6_new");

    for (int i = 0; i < 8; i++) begin
      s = int'($urandom_range(0, 2));
      d = 9'($urandom);
      sel = 2'(s);
      wr_one(s, d);
      tick();
      chk("rand_start", 32'(tx_s), 32'(0));
      rx_frame(s == 1 ? 7 : 8, s == 0 ? 1 : s == 1 ? 0 : 2, s == 1 ? 2 : 1, d, 0, "rand");
      chk("rand_idle", 32'(busy_s), 32'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
